// File: rtl/nbit_addsub_pkg.sv
// -----------------------------------------------------------------------------
// nbit_addsub_pkg
// Shared helpers for the pipelined signed add/sub:
//   stages(n, chunk) : number of carry-chain pipeline stages (n / chunk)
//   cfg_ok(n, chunk) : elaboration check that the operand width splits into
//                      whole chunks
// -----------------------------------------------------------------------------
package nbit_addsub_pkg;

  function automatic int stages(input int n, input int chunk);
    return n / chunk;
  endfunction

  function automatic bit cfg_ok(input int n, input int chunk);
    return (chunk > 0) && (n >= chunk) && ((n % chunk) == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  [W-1:0] addends (b already inverted by the caller for subtraction)
//   cin           carry into bit 0
//   s     [W-1:0] sum bits
//   cout          carry out of bit W-1
// -----------------------------------------------------------------------------
module addsub_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/nbit_addsub_pipe.sv
// -----------------------------------------------------------------------------
// nbit_addsub_pipe
// Pipelined signed N-bit adder/subtractor with valid/ready handshake.
// The N+1-bit carry chain is cut into S = N/CHUNK stages; one CHUNK-bit slice
// is resolved per stage while the untouched operand bits and the finished sum
// bits travel alongside in skew registers.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand beat handshake (in_ready = advance enable)
//   a, b  [N-1:0]       signed operands
//   sub                 0: a+b, 1: a-b
//   out_valid/out_ready result beat handshake
//   sum   [N:0]         exact signed result
//   sat   [N-1:0]       result clamped to the N-bit signed range
//   ovf                 exact result does not fit in N bits
// Latency S cycles from acceptance, throughput one beat per cycle.
// -----------------------------------------------------------------------------
module nbit_addsub_pipe
  import nbit_addsub_pkg::*;
#(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic [N-1:0] sat,
  output logic         ovf
);

  localparam int S  = stages(N, CHUNK);
  localparam int NW = N + 1;

  if (!cfg_ok(N, CHUNK)) begin : g_bad_cfg
    $error("nbit_addsub_pipe: N must be a non-zero multiple of CHUNK");
  end

  // Level i (0..S-1) feeds stage i; level S is the output register.
  logic [S:0]           v_reg,  v_next;
  logic [S-1:0]         c_reg,  c_next;
  logic [S-1:0][NW-1:0] a_reg,  a_next;
  logic [S-1:0][NW-1:0] b_reg,  b_next;
  logic [S-1:0][NW-1:0] s_reg,  s_next;
  logic [NW-1:0]        sum_reg, sum_next;
  logic [N-1:0]         sat_reg, sat_next;
  logic                 ovf_reg, ovf_next;
  logic                 en;

  // Whole pipeline moves as one; it only freezes when a finished result is
  // waiting on a consumer that is not ready.
  assign en        = !v_reg[S] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_reg[S];
  assign sum       = sum_reg;
  assign sat       = sat_reg;
  assign ovf       = ovf_reg;

  // Entry level: sign-extend, and fold subtraction into ~b with carry-in 1.
  assign v_next[0] = in_valid;
  assign c_next[0] = sub;
  assign a_next[0] = {a[N-1], a};
  assign b_next[0] = sub ? ~{b[N-1], b} : {b[N-1], b};
  assign s_next[0] = '0;

  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;
    logic [NW-1:0]    merged;

    addsub_chunk #(.W(CHUNK)) u_chunk (
      .a    (a_reg[gi][gi*CHUNK +: CHUNK]),
      .b    (b_reg[gi][gi*CHUNK +: CHUNK]),
      .cin  (c_reg[gi]),
      .s    (chunk_s),
      .cout (chunk_c)
    );

    // Sum bits at and above this chunk are still zero, so OR-ing the new
    // slice in is equivalent to a field insert.
    assign merged = s_reg[gi] | (NW'(chunk_s) << (gi * CHUNK));

    assign v_next[gi + 1] = v_reg[gi];

    if (gi < S - 1) begin : g_mid
      assign c_next[gi + 1] = chunk_c;
      assign a_next[gi + 1] = a_reg[gi];
      assign b_next[gi + 1] = b_reg[gi];
      assign s_next[gi + 1] = merged;
    end else begin : g_last
      logic ext_bit;
      logic unused_tail;

      // The sign-extension bit is resolved here together with the top chunk.
      assign ext_bit  = a_reg[gi][N] ^ b_reg[gi][N] ^ chunk_c;
      assign sum_next = merged | {ext_bit, {N{1'b0}}};
      assign ovf_next = sum_next[N] ^ sum_next[N-1];
      assign sat_next = !ovf_next  ? sum_next[N-1:0] :
                        sum_next[N] ? {1'b1, {(N-1){1'b0}}} :
                                      {1'b0, {(N-1){1'b1}}};

      // Operand bits left after the final chunk have no consumer.
      assign unused_tail = ^{a_reg[gi], b_reg[gi]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg   <= '0;
      c_reg   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      s_reg   <= '0;
      sum_reg <= '0;
      sat_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (en) begin
      v_reg   <= v_next;
      c_reg   <= c_next;
      a_reg   <= a_next;
      b_reg   <= b_next;
      s_reg   <= s_next;
      sum_reg <= sum_next;
      sat_reg <= sat_next;
      ovf_reg <= ovf_next;
    end
  end

endmodule

// File: tb/tb_nbit_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_nbit_addsub_pipe
// Self-checking bench: directed latency/overflow/reset/backpressure cases,
// a random stream against an integer reference model, and single-beat checks
// on N=4 (S=1) and N=16 (S=4) instances.
// -----------------------------------------------------------------------------
module tb_nbit_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default configuration N=8, CHUNK=4
  logic       in_valid, in_ready, sub, out_valid, out_ready, ovf;
  logic [7:0] a, b, sat;
  logic [8:0] sum;

  // N=4, CHUNK=4
  logic       iv4, ir4, sub4, ov4, or4, ovf4;
  logic [3:0] a4, b4, sat4;
  logic [4:0] sum4;

  // N=16, CHUNK=4
  logic        iv16, ir16, sub16, ov16, or16, ovf16;
  logic [15:0] a16, b16, sat16;
  logic [16:0] sum16;

  nbit_addsub_pipe #(.N(8), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sat(sat), .ovf(ovf)
  );

  nbit_addsub_pipe #(.N(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .sub(sub4), .out_valid(ov4), .out_ready(or4),
    .sum(sum4), .sat(sat4), .ovf(ovf4)
  );

  nbit_addsub_pipe #(.N(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
    .sum(sum16), .sat(sat16), .ovf(ovf16)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the signed operands.
  typedef struct {
    logic [8:0] sum;
    logic [7:0] sat;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int   r;
    exp_t e;
    r = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    e.sum = r[8:0];
    e.ovf = (r > 127) || (r < -128);
    if (r > 127)       e.sat = 8'h7F;
    else if (r < -128) e.sat = 8'h80;
    else               e.sat = r[7:0];
    return e;
  endfunction

  function automatic logic [7:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 8'h7F;
      1:       return 8'h80;
      2:       return 8'hFF;
      3:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1'b1);
        check("stall_data_hold", {sum, sat, ovf}, prev_out);
      end
      if (out_valid && out_ready) begin
        check("result_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          $display("retire: sum=0x%03h sat=0x%02h ovf=%0b", sum, sat, ovf);
          check("sb_sum", sum, e.sum);
          check("sb_sat", sat, e.sat);
          check("sb_ovf", ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      prev_stall <= out_valid && !out_ready;
      prev_out   <= {sum, sat, ovf};
    end
  end

  // Single isolated beat on the N=8 instance: latency and exact values.
  task automatic timed_beat(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic s, input logic [8:0] e_sum,
                            input logic [7:0] e_sat, input logic e_ovf);
    int n;
    @(posedge clk); #1;
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 2);
    check({tag, "_sum"}, sum, e_sum);
    check({tag, "_sat"}, sat, e_sat);
    check({tag, "_ovf"}, ovf, e_ovf);
  endtask

  // Present a beat and hold it until the block takes it.
  task automatic push_beat(input logic [7:0] x, input logic [7:0] y, input logic s);
    int   guard;
    logic took;
    a = x; b = y; sub = s; in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!took && guard < 50);
    check("beat_accepted", took, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; or4 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; or16 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sum", sum, 9'h000);
    check("rst_sat", sat, 8'h00);
    check("rst_ovf", ovf, 1'b0);

    // Chunk carry propagation and overflow boundaries
    timed_beat("carry_add", 8'h0F, 8'h01, 1'b0, 9'h010, 8'h10, 1'b0);
    timed_beat("carry_sub", 8'h10, 8'h01, 1'b1, 9'h00F, 8'h0F, 1'b0);
    timed_beat("fit_max",   8'd100, 8'd27, 1'b0, 9'h07F, 8'h7F, 1'b0);
    timed_beat("ovf_pos",   8'd100, 8'd28, 1'b0, 9'h080, 8'h7F, 1'b1);
    timed_beat("ovf_neg",   8'h80, 8'h01, 1'b1, 9'h17F, 8'h80, 1'b1);

    // Reset with two beats in flight
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("flush_out_valid", out_valid, 1'b0);
    end

    // Backpressure: 4 back-to-back beats, 3-cycle stall on first result
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 4; k++) push_beat(pick_op(), pick_op(), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        int m;
        m = 0;
        while (!out_valid && m < 20) begin
          @(posedge clk); #1;
          m++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 1'b0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1 check("bp_all_delivered", exp_q.size(), 0);

    // Full-rate streaming: 16 beats, one result per cycle after fill
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          a = pick_op(); b = pick_op(); sub = 1'($urandom); in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        check("tp_fill", n, 3);
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          check("tp_out_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        check("tp_drained", out_valid, 1'b0);
      end
    join

    // Random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick_op();
      b         = pick_op();
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("rand_all_delivered", exp_q.size(), 0);

    // N=4 (S=1): latency 1, 7+1 overflows
    @(posedge clk); #1;
    a4 = 4'h7; b4 = 4'h1; sub4 = 1'b0; iv4 = 1'b1;
    check("n4_in_ready", ir4, 1'b1);
    @(posedge clk); #1;
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("n4_latency", n, 1);
    check("n4_sum", sum4, 5'h08);
    check("n4_sat", sat4, 4'h7);
    check("n4_ovf", ovf4, 1'b1);

    // N=16 (S=4): latency 4, 0x7FFF+1 overflows
    @(posedge clk); #1;
    a16 = 16'h7FFF; b16 = 16'h0001; sub16 = 1'b0; iv16 = 1'b1;
    check("n16_in_ready", ir16, 1'b1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 0;
    while (!ov16 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("n16_latency", n, 4);
    check("n16_sum", sum16, 17'h08000);
    check("n16_sat", sat16, 16'h7FFF);
    check("n16_ovf", ovf16, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nbit_addsub_pipe.md
# nbit_addsub_pipe

Pipelined, parametrised signed N-bit adder/subtractor with valid/ready handshake, overflow detection and a saturated result. It is the streaming successor to the combinational ripple add/sub. The carry chain is split into CHUNK-bit stages separated by registers, so wide operands close timing at full clock rate. It sits between operand producers (register file, ALU front end) and any consumer that can apply backpressure.

## Interface
- N, default 8: operand width, two's complement signed; must be a multiple of CHUNK.
- CHUNK, default 4: bits of carry chain resolved per pipeline stage; S = N/CHUNK stages.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts beat this cycle.
- a  input  N  signed operand A.
- b  input  N  signed operand B.
- sub  input  1  0: A+B, 1: A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  N+1  exact signed result (sign-extended, never overflows).
- sat  output  N  result clamped to [−2^(N−1), 2^(N−1)−1].
- ovf  output  1  exact result does not fit in N bits.

## Operation
- Operands sign-extended to N+1 bits. For sub=1, B is inverted and carry-in=1 (A + ~B + 1).
- Stage i (0..S−1) adds bits [i·CHUNK +: CHUNK] with the carry registered from stage i−1. The top extension bit is added in stage S−1. Unprocessed operand bits and completed sum bits are carried forward in skew registers.
- ovf = sum[N] XOR sum[N−1].
- sat = sum[N−1:0] if !ovf; 0x7F.. if ovf and sum[N]=0; 0x80.. if ovf and sum[N]=1.
- Global advance enable: en = !out_valid | out_ready. All stages shift together when en=1 and hold when en=0.
- in_ready = en. A beat transfers on in_valid & in_ready.
- Stage valid bits propagate with the data. Bubbles are not collapsed.
- Results leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset (async assert, any cycle including mid-transaction): all stage valids=0, out_valid=0, sum=0, sat=0, ovf=0. All in-flight beats are discarded. in_ready=1 in the first cycle after release.
- Latency: a beat accepted at edge t has out_valid=1 after edge t+S, provided no stall occurs.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: when out_valid=1 & out_ready=0, in_ready=0 combinationally. sum, sat and ovf are held stable until the handshake completes.
- out_valid & out_ready together with in_valid in the same cycle: output retires, new beat enters, pipeline shifts by one.
- out_valid does not depend combinationally on out_ready. in_ready depends combinationally on out_ready only.
- in_valid=0 while en=1 inserts a bubble (stage valid=0). Its data contents don't care.

## Structure
- Package nbit_addsub_pkg holds the stage-count function, stages(N, CHUNK), and the elaboration check N % CHUNK == 0.
- Sub-module addsub_chunk (parameter W=CHUNK) is a combinational W-bit ripple of full_adder cells: inputs a, b, cin; outputs s, cout.
- The top level instantiates S addsub_chunk copies in a generate loop, plus the valid/skew registers and the saturation/overflow logic on the last stage.

## Test plan
Default parameters (N=8, CHUNK=4, S=2) unless noted.
- Reset: hold rst, then release → out_valid=0, in_ready=1, sum=9'h000, sat=8'h00, ovf=0. Assert rst while 2 beats are in flight → both lost; out_valid stays 0.
- Chunk carry: 0x0F+0x01 → sum=9'h010. Sub 0x10−0x01 → sum=9'h00F, ovf=0. Both have out_valid exactly 2 cycles after acceptance.
- Overflow: 100+27 → sum=127, sat=8'h7F, ovf=0. 100+28 → sum=9'h080, sat=8'h7F, ovf=1. −128−1 → sum=9'h17F, sat=8'h80, ovf=1.
- Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles once the first result appears → in_ready=0 during the stall, output held stable, all 4 results delivered in order with no loss.
- Simultaneous retire/accept with out_ready=1 and in_valid=1 continuous for 16 beats → one result per cycle after the 2-cycle fill.
- Parameter sweep: N=4, CHUNK=4 (S=1) gives latency 1, and 7+1 → ovf=1, sat=4'h7. N=16, CHUNK=4 (S=4) gives latency 4, and 0x7FFF+1 → sum=17'h08000, ovf=1.
